// File: rtl/exec_writeback_unit.sv
// Execute / write-back stage for the multi-cycle CPU datapath.
// The stage latches a decoded op and drives the register-file read addresses.
// It captures the operands and computes the result: one cycle for simple ops,
// or a DATA_W-step shift-add for MUL. It then presents a one-cycle write to
// the register file.
module exec_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [3:0]        Op,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              Busy,
  output logic              Done,
  output logic              Zero,
  output logic              Overflow
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   r_addr_a_q, r_addr_a_d;
  logic [ADDR_W-1:0]   r_addr_b_q, r_addr_b_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                write_reg_q, write_reg_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;

  logic [DATA_W-1:0]   sum, diff, mul_acc, alu_res;
  logic                alu_ovf, alu_valid, load;

  // ALU: combinational result from the captured operands; MUL result is the
  // accumulator after the current step has been folded in.
  always_comb begin
    sum       = a_q + b_q;
    diff      = a_q - b_q;
    mul_acc   = acc_q + (b_q[0] ? a_q : '0);
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_valid = 1'b1;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SLL: alu_res = b_q << a_q[SH_W-1:0];
      OP_SRL: alu_res = b_q >> a_q[SH_W-1:0];
      OP_MUL: alu_res = mul_acc;
      default: begin
        alu_res   = '0;
        alu_valid = 1'b0;
      end
    endcase
  end

  // Next-state and output-register logic for the IDLE/READ/EXEC/WB sequence.
  always_comb begin
    state_d     = state_q;
    r_addr_a_d  = r_addr_a_q;
    r_addr_b_d  = r_addr_b_q;
    op_d        = op_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    write_reg_d = write_reg_q;
    done_d      = done_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          r_addr_a_d = Rs;
          r_addr_b_d = Rt;
          op_d       = Op;
          rd_d       = Rd;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        a_d     = R_Data_A;
        b_d     = R_Data_B;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          acc_d = mul_acc;
          cnt_d = cnt_q + CNT_W'(1);
          load  = (cnt_q == LAST_STEP);
        end else begin
          load = 1'b1;
        end
      end
      S_WB: begin
        write_reg_d = 1'b0;
        done_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result presentation; overflow or an invalid op or Rd==0 suppress the write.
    if (load) begin
      w_data_d    = alu_res;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
      w_addr_d    = rd_q;
      write_reg_d = alu_valid && (rd_q != '0) && !alu_ovf;
      done_d      = 1'b1;
      state_d     = S_WB;
    end
  end

  // State register with asynchronous clear; reset abandons any in-flight op.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      r_addr_a_q  <= '0;
      r_addr_b_q  <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      write_reg_q <= 1'b0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_addr_a_q  <= r_addr_a_d;
      r_addr_b_q  <= r_addr_b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      write_reg_q <= write_reg_d;
      done_q      <= done_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign R_Addr_A  = r_addr_a_q;
  assign R_Addr_B  = r_addr_b_q;
  assign W_Addr    = w_addr_q;
  assign W_Data    = w_data_q;
  assign Write_Reg = write_reg_q;
  assign Done      = done_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Bench for exec_writeback_unit: a behavioural register file plus a reference
// ALU model. It runs directed corner cases and then randomized ops.
module tb_exec_writeback_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [3:0]  Op;
  logic [4:0]  Rs, Rt, Rd;
  logic [31:0] R_Data_A, R_Data_B;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg, Busy, Done, Zero, Overflow;

  int tests = 0;
  int fails = 0;

  exec_writeback_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Busy(Busy), .Done(Done), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  // Register file: combinational read, write on clock edge, plus a backdoor load port.
  logic [31:0] regs [32];
  logic [31:0] exp_regs [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_count = 0;

  assign R_Data_A = regs[R_Addr_A];
  assign R_Data_B = regs[R_Addr_B];

  always @(posedge Clk) begin
    if (bd_we) regs[bd_addr] <= bd_data;
    else if (Write_Reg && W_Addr != 5'd0) regs[W_Addr] <= W_Data;
    if (Write_Reg) wr_count <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: arithmetic on wide signed/unsigned values.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ovf, output logic valid);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ovf = 1'b0; valid = 1'b1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin s = sa + sb; r = s[31:0]; ovf = (s[32] != s[31]); end
      4'd3: begin s = sa - sb; r = s[31:0]; ovf = (s[32] != s[31]); end
      4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = ~(a | b);
      4'd7: r = b << a[4:0];
      4'd8: r = b >> a[4:0];
      4'd9: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default: valid = 1'b0;
    endcase
  endfunction

  task automatic set_reg(input int i, input logic [31:0] v);
    @(negedge Clk); bd_we = 1'b1; bd_addr = 5'(i); bd_data = v;
    @(negedge Clk); bd_we = 1'b0;
    exp_regs[i] = v;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    logic [31:0] a, b, r;
    logic ovf, valid, wr, early;
    int cyc, lat;
    a = exp_regs[rs]; b = exp_regs[rt];
    model(op, a, b, r, ovf, valid);
    wr  = valid && (rd != 5'd0) && !ovf;
    lat = (op == 4'd9) ? 34 : 3;
    @(negedge Clk); Start = 1'b1; Op = op; Rs = rs; Rt = rt; Rd = rd;
    @(posedge Clk); #1 Start = 1'b0;
    cyc = 0; early = 1'b0;
    while (Done !== 1'b1 && cyc < 60) begin
      @(negedge Clk); cyc++;
      if (Done !== 1'b1 && Write_Reg === 1'b1) early = 1'b1;
    end
    $display("[TB] op=%0d rs=%0d rt=%0d rd=%0d a=%h b=%h -> W_Data=%h wr=%0b ovf=%0b zero=%0b lat=%0d",
             op, rs, rt, rd, a, b, W_Data, Write_Reg, Overflow, Zero, cyc);
    chk("latency", 32'(cyc), 32'(lat));
    chk("wr_early", {31'd0, early}, 32'd0);
    chk("busy_at_done", {31'd0, Busy}, 32'd1);
    chk("w_data", W_Data, r);
    chk("w_addr", {27'd0, W_Addr}, {27'd0, rd});
    chk("write_reg", {31'd0, Write_Reg}, {31'd0, wr});
    chk("zero", {31'd0, Zero}, {31'd0, (r == 32'd0)});
    chk("overflow", {31'd0, Overflow}, {31'd0, ovf});
    if (wr) exp_regs[rd] = r;
    @(negedge Clk);
    chk("write_reg_drop", {31'd0, Write_Reg}, 32'd0);
    chk("done_drop", {31'd0, Done}, 32'd0);
    chk("busy_drop", {31'd0, Busy}, 32'd0);
    chk("w_data_hold", W_Data, r);
    chk("regfile", regs[rd], exp_regs[rd]);
  endtask

  initial begin
    int base, cyc;
    Reset = 1'b1; Start = 1'b0; Op = '0; Rs = '0; Rt = '0; Rd = '0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_wdata", W_Data, 32'd0);
    chk("rst_raddr", {22'd0, R_Addr_A, R_Addr_B}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 32; i++) set_reg(i, (i == 0) ? 32'd0 : $urandom);

    // Directed cases
    set_reg(1, 32'd5); set_reg(2, 32'd7); set_reg(3, 32'd0);
    do_op(4'd2, 5'd1, 5'd2, 5'd3);                       // 5+7 -> 12
    set_reg(5, 32'h7FFF_FFFF); set_reg(7, 32'd1);
    do_op(4'd2, 5'd5, 5'd7, 5'd4);                       // overflow, no write
    do_op(4'd3, 5'd1, 5'd1, 5'd8);                       // 5-5 -> zero
    set_reg(9, 32'hFFFF_FFFF); set_reg(10, 32'd3);
    do_op(4'd9, 5'd9, 5'd10, 5'd6);                      // -> FFFFFFFD
    set_reg(11, 32'd1234); set_reg(12, 32'd5678);
    do_op(4'd9, 5'd11, 5'd12, 5'd13);                    // -> 7006652
    do_op(4'd4, 5'd9, 5'd7, 5'd14);                      // -1 < 1
    set_reg(15, 32'd31); set_reg(16, 32'h8000_0000);
    do_op(4'd8, 5'd15, 5'd16, 5'd17);                    // SRL -> 1
    do_op(4'd7, 5'd15, 5'd7, 5'd18);                     // SLL -> 80000000
    do_op(4'd12, 5'd1, 5'd2, 5'd19);                     // invalid op
    do_op(4'd2, 5'd1, 5'd2, 5'd0);                       // Rd=0

    // Dependent back-to-back with Start held high throughout
    set_reg(3, 32'd0); set_reg(4, 32'd0);
    base = wr_count;
    @(negedge Clk); Start = 1'b1; Op = 4'd2; Rs = 5'd1; Rt = 5'd2; Rd = 5'd3;
    @(posedge Clk); #1 Rs = 5'd3; Rt = 5'd3; Rd = 5'd4;
    cyc = 0;
    @(negedge Clk);
    while (Busy === 1'b1 && cyc < 60) begin @(negedge Clk); cyc++; end
    @(posedge Clk); #1 Start = 1'b0;
    while (Busy === 1'b1 && cyc < 120) begin @(negedge Clk); cyc++; end
    @(negedge Clk);
    $display("[TB] back-to-back: R3=%h R4=%h writes=%0d", regs[3], regs[4], wr_count - base);
    chk("b2b_r3", regs[3], 32'd12);
    chk("b2b_r4", regs[4], 32'd24);
    chk("b2b_writes", 32'(wr_count - base), 32'd2);
    exp_regs[3] = 32'd12; exp_regs[4] = 32'd24;

    // Reset during MUL step 10
    set_reg(6, 32'h0000_0BAD);
    base = wr_count;
    @(negedge Clk); Start = 1'b1; Op = 4'd9; Rs = 5'd9; Rt = 5'd10; Rd = 5'd6;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (12) @(negedge Clk);
    Reset = 1'b1; #1;
    $display("[TB] reset mid-MUL: Busy=%0b W_Data=%h", Busy, W_Data);
    chk("mr_busy", {31'd0, Busy}, 32'd0);
    chk("mr_write", {31'd0, Write_Reg}, 32'd0);
    chk("mr_done", {31'd0, Done}, 32'd0);
    chk("mr_wdata", W_Data, 32'd0);
    chk("mr_flags", {30'd0, Zero, Overflow}, 32'd0);
    chk("mr_addrs", {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 32'd0);
    @(negedge Clk); Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mr_busy_after", {31'd0, Busy}, 32'd0);
    chk("mr_no_write", 32'(wr_count - base), 32'd0);
    chk("mr_reg6", regs[6], exp_regs[6]);
    do_op(4'd9, 5'd11, 5'd12, 5'd6);

    // Randomized ops
    for (int n = 0; n < 24; n++) begin
      do_op(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
